// File: rtl/module_control_suma.sv
// module_control_suma
// Keypad-driven control for a BCD adder. Collects operand A, then operand B
// (after '+'), hands both to an external combinational BCD adder, latches the
// adder's sum on '=' and holds it for display.
//
// Parameters:
//   N_DIGITOS   BCD digits per operand; operand width W = 4*N_DIGITOS
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tecla_valid one-cycle strobe qualifying tecla
//   tecla       key code: 0-9 digit, A '+', B '=', C clear, D-F unused
//   s           BCD sum (W+1 bits) from the external adder fed by a and b
//   a, b        registered operands to the adder
//   disp        registered display digits (W+4 bits)
//   estado      current state: 0 CARGA_A, 1 CARGA_B, 2 SUMA, 3 MUESTRA
//   listo       high while a valid result is held in MUESTRA
// Build option:
//   CTRL_AUTO_CLEAR_EN  a digit key in MUESTRA clears and starts a new A
//                       with that digit; when undefined, only clear exits
//                       MUESTRA.

module module_control_suma #(
  parameter int unsigned N_DIGITOS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tecla_valid,
  input  logic [3:0]                 tecla,
  input  logic [4*N_DIGITOS:0]       s,
  output logic [4*N_DIGITOS-1:0]     a,
  output logic [4*N_DIGITOS-1:0]     b,
  output logic [4*N_DIGITOS+3:0]     disp,
  output logic [1:0]                 estado,
  output logic                       listo
);

  localparam int unsigned W  = 4 * N_DIGITOS;
  localparam int unsigned CW = $clog2(N_DIGITOS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(N_DIGITOS);

  localparam logic [3:0] K_MAS   = 4'hA;
  localparam logic [3:0] K_IGUAL = 4'hB;
  localparam logic [3:0] K_CLR   = 4'hC;

  typedef enum logic [1:0] {
    CARGA_A = 2'd0,
    CARGA_B = 2'd1,
    SUMA    = 2'd2,
    MUESTRA = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [W-1:0]    a_n, b_n;
  logic [W:0]      result, result_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W+3:0]    disp_n;
  logic            listo_n;

  logic es_digito, es_mas, es_igual, es_clr;

  assign es_digito = tecla_valid && (tecla <= 4'h9);
  assign es_mas    = tecla_valid && (tecla == K_MAS);
  assign es_igual  = tecla_valid && (tecla == K_IGUAL);
  assign es_clr    = tecla_valid && (tecla == K_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CARGA_A;
      a      <= '0;
      b      <= '0;
      result <= '0;
      cnt    <= '0;
      disp   <= '0;
      listo  <= 1'b0;
    end else begin
      state  <= state_n;
      a      <= a_n;
      b      <= b_n;
      result <= result_n;
      cnt    <= cnt_n;
      disp   <= disp_n;
      listo  <= listo_n;
    end
  end

  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    result_n = result;
    cnt_n    = cnt;

    if (es_clr) begin
      state_n  = CARGA_A;
      a_n      = '0;
      b_n      = '0;
      result_n = '0;
      cnt_n    = '0;
    end else begin
      unique case (state)
        CARGA_A: begin
          if (es_digito && (cnt < MAX_CNT)) begin
            a_n   = (a << 4) | W'(tecla);
            cnt_n = cnt + 1'b1;
          end else if (es_mas) begin
            state_n = CARGA_B;
            b_n     = '0;
            cnt_n   = '0;
          end
        end
        CARGA_B: begin
          if (es_digito && (cnt < MAX_CNT)) begin
            b_n   = (b << 4) | W'(tecla);
            cnt_n = cnt + 1'b1;
          end else if (es_igual) begin
            state_n = SUMA;
          end
        end
        SUMA: begin
          // a and b have been stable for a full cycle, so the adder output is settled.
          result_n = s;
          state_n  = MUESTRA;
        end
        MUESTRA: begin
`ifdef CTRL_AUTO_CLEAR_EN
          if (es_digito) begin
            state_n  = CARGA_A;
            a_n      = W'(tecla);
            b_n      = '0;
            result_n = '0;
            cnt_n    = CW'(1);
          end
`endif
        end
        default: state_n = CARGA_A;
      endcase
    end
  end

  // disp and listo are registered from next-state values so they always
  // match the state that is current after the edge.
  always_comb begin
    disp_n = '0;
    unique case (state_n)
      CARGA_A:       disp_n = {4'h0, a_n};
      CARGA_B, SUMA: disp_n = {4'h0, b_n};
      MUESTRA:       disp_n = {3'b000, result_n};
      default:       disp_n = '0;
    endcase
    listo_n = (state_n == MUESTRA);
  end

  assign estado = state;

endmodule

// File: tb/tb_module_control_suma.sv
module tb_module_control_suma;

  localparam int unsigned ND = 3;
  localparam int unsigned W  = 4 * ND;

  logic          clk;
  logic          rst_n;
  logic          tecla_valid;
  logic [3:0]    tecla;
  logic [W:0]    s;
  logic [W-1:0]  a, b;
  logic [W+3:0]  disp;
  logic [1:0]    estado;
  logic          listo;

  int errors = 0;
  int checks = 0;

  module_control_suma #(.N_DIGITOS(ND)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tecla_valid (tecla_valid),
    .tecla       (tecla),
    .s           (s),
    .a           (a),
    .b           (b),
    .disp        (disp),
    .estado      (estado),
    .listo       (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External BCD adder the controller drives.
  function automatic logic [W:0] bcd_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    int c, d;
    r = '0;
    c = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
      if (d > 9) begin
        d = d - 10;
        c = 1;
      end else begin
        c = 0;
      end
      r[4*i +: 4] = 4'(d);
    end
    r[W] = c[0];
    return r;
  endfunction

  always_comb s = bcd_add(a, b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One key per cycle; outputs are sampled 1 ns after the capturing edge.
  task automatic press(input logic [3:0] k);
    tecla_valid = 1'b1;
    tecla       = k;
    @(posedge clk);
    #1;
    tecla_valid = 1'b0;
    tecla       = 4'h0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    tecla_valid = 1'b0;
    tecla       = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_a",      32'(a),      32'h0);
    check("rst_b",      32'(b),      32'h0);
    check("rst_disp",   32'(disp),   32'h0);
    check("rst_listo",  32'(listo),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 130 + 100
    press(4'h1);
    check("first_key_a", 32'(a), 32'h001);
    press(4'h3);
    press(4'h0);
    check("t1_a",       32'(a),      32'h130);
    check("t1_disp_a",  32'(disp),   32'h0130);
    press(4'hA);
    check("t1_plus_st", 32'(estado), 32'd1);
    check("t1_disp_b0", 32'(disp),   32'h0000);
    press(4'h1);
    press(4'h0);
    press(4'h0);
    check("t1_b",       32'(b),      32'h100);
    press(4'hB);
    check("t1_suma_st", 32'(estado), 32'd2);
    check("t1_suma_li", 32'(listo),  32'd0);
    check("t1_suma_dp", 32'(disp),   32'h0100);
    idle();
    check("t1_listo",   32'(listo),  32'd1);
    check("t1_estado",  32'(estado), 32'd3);
    check("t1_disp",    32'(disp),   32'h0230);
    check("t1_a_hold",  32'(a),      32'h130);
    check("t1_b_hold",  32'(b),      32'h100);
    press(4'hA);
    check("t1_plus_ign", 32'(estado), 32'd3);
    press(4'h5);
`ifdef CTRL_AUTO_CLEAR_EN
    check("t1_auto_st",  32'(estado), 32'd0);
    check("t1_auto_a",   32'(a),      32'h005);
    check("t1_auto_li",  32'(listo),  32'd0);
`else
    check("t1_dig_st",   32'(estado), 32'd3);
    check("t1_dig_disp", 32'(disp),   32'h0230);
`endif
    press(4'hC);
    check("clr_estado", 32'(estado), 32'd0);
    check("clr_a",      32'(a),      32'h0);
    check("clr_b",      32'(b),      32'h0);
    check("clr_disp",   32'(disp),   32'h0);
    check("clr_listo",  32'(listo),  32'd0);

    // 200 + 300, with '+' in CARGA_B and a key during SUMA both ignored
    press(4'h2); press(4'h0); press(4'h0);
    press(4'hA);
    press(4'h3); press(4'h0); press(4'h0);
    press(4'hA);
    check("t2_plus_ign", 32'(estado), 32'd1);
    check("t2_b",        32'(b),      32'h300);
    press(4'hB);
    press(4'h7);
    check("t2_s",       32'(s),      32'h0500);
    check("t2_estado",  32'(estado), 32'd3);
    check("t2_disp",    32'(disp),   32'h0500);
    press(4'hC);

    // 999 + 999 carries into the top digit
    press(4'h9); press(4'h9); press(4'h9);
    press(4'hA);
    press(4'h9); press(4'h9); press(4'h9);
    press(4'hB);
    idle();
    check("t3_disp",  32'(disp),  32'h1998);
    check("t3_listo", 32'(listo), 32'd1);
    press(4'hC);

    // Digit overflow, '=' in CARGA_A, unused code, unqualified key
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("t4_a_full",  32'(a),      32'h123);
    press(4'hB);
    check("t4_eq_ign",  32'(estado), 32'd0);
    press(4'hD);
    check("t4_d_ign",   32'(a),      32'h123);
    tecla_valid = 1'b0;
    tecla       = 4'h5;
    idle();
    tecla       = 4'h0;
    check("t4_nv_ign",  32'(a),      32'h123);
    press(4'hC);

    // '+' with no digits gives A = 0; then reset during SUMA
    press(4'hA);
    check("t5_empty_st", 32'(estado), 32'd1);
    check("t5_empty_a",  32'(a),      32'h0);
    press(4'h7);
    press(4'hB);
    check("t5_suma",    32'(estado), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_arst_st",   32'(estado), 32'd0);
    check("t5_arst_b",    32'(b),      32'h0);
    check("t5_arst_disp", 32'(disp),   32'h0);
    check("t5_arst_li",   32'(listo),  32'd0);
    idle();
    rst_n = 1'b1;
    idle();
    check("t5_post_li",  32'(listo),  32'd0);
    idle();
    check("t5_post_li2", 32'(listo),  32'd0);
    check("t5_post_st",  32'(estado), 32'd0);
    check("t5_post_dp",  32'(disp),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/module_control_suma.md
MODULE_CONTROL_SUMA -- requirements
Module: module_control_suma

Interface
REQ-001 Parameter: N_DIGITOS, default 3, BCD digits per operand; operand width W = 4*N_DIGITOS.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 tecla_valid  input  1  one-cycle strobe; tecla is valid this cycle.
REQ-006 tecla  input  4  key code: 0x0-0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD-0xF unused.
REQ-007 s  input  W+1  BCD sum from the combinational adder, driven by a and b.
REQ-008 a  output  W  operand A to the adder (registered).
REQ-009 b  output  W  operand B to the adder (registered).
REQ-010 disp  output  W+4  BCD digits for the display (registered).
REQ-011 estado  output  2  current state: 0 CARGA_A, 1 CARGA_B, 2 SUMA, 3 MUESTRA.
REQ-012 listo  output  1  high while a valid result is held in MUESTRA.

Function
REQ-013 The FSM SHALL have these states: CARGA_A, CARGA_B, SUMA, MUESTRA.
REQ-014 A digit key in CARGA_A (or CARGA_B) with fewer than N_DIGITOS digits entered SHALL shift a (or b) left by 4 bits and insert the digit in bits [3:0].
REQ-015 Once N_DIGITOS digits are entered, further digits SHALL be ignored and the operand held.
REQ-016 '+' in CARGA_A SHALL move the FSM to CARGA_B, clear b, and clear the digit count; with no digits entered, A = 0.
REQ-017 '=' in CARGA_B SHALL move the FSM to SUMA on the next edge; on the following edge, s SHALL be latched into the result register, the FSM SHALL move to MUESTRA, and listo SHALL go to 1 (two cycles from the '=' strobe to listo).
REQ-018 The block SHALL ignore '=' in CARGA_A, '+' in CARGA_B or MUESTRA, codes 0xD-0xF, and all keys while in SUMA.
REQ-019 Clear (0xC) in any state SHALL zero a, b, the result, and the digit count, set listo to 0, and move the FSM to CARGA_A on the next edge.
REQ-020 disp SHALL equal {4'h0, a} in CARGA_A and {4'h0, b} in CARGA_B and SUMA.
REQ-021 In MUESTRA, disp SHALL equal {3'b000, result}.
REQ-022 a and b SHALL remain stable during SUMA and MUESTRA.
REQ-023 The block SHALL process at most one key per cycle; tecla SHALL be ignored when tecla_valid = 0.

Reset
REQ-024 While rst_n = 0: state = CARGA_A, a = 0, b = 0, result = 0, digit count = 0, disp = 0, listo = 0.
REQ-025 Reset asserted mid-operation, including during SUMA, SHALL abort the operation with no partial result retained.
REQ-026 The first key after rst_n deasserts SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro CTRL_AUTO_CLEAR_EN defined: a digit key in MUESTRA SHALL perform an implicit clear and then load that digit as the first digit of A, entering CARGA_A.
REQ-028 Macro CTRL_AUTO_CLEAR_EN undefined: digit keys in MUESTRA SHALL be ignored; only clear exits MUESTRA.

Verification
REQ-029 Keys 1,3,0,+,1,0,0,= -> a=0x130, b=0x100; listo=1 two cycles after '='; disp=0x0230.
REQ-030 Keys 2,0,0,+,3,0,0,= -> s=0x0500; result latched; estado=3.
REQ-031 Keys 9,9,9,+,9,9,9,= -> disp=0x1998, listo=1.
REQ-032 Keys 1,2,3,4 -> a=0x123 with the fourth digit ignored; then '=' -> estado stays 0.
REQ-033 Assert rst_n=0 during SUMA -> all outputs 0, estado=0 asynchronously; no listo pulse after release.
REQ-034 In MUESTRA, key 5 -> with CTRL_AUTO_CLEAR_EN: estado=0, a=0x005; without it: state and disp unchanged.
